// File: rtl/afisaj_7seg_mux_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package afisaj_7seg_mux_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/afisaj_7seg_mux_decod_bcd_7seg.sv
// BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module decod_bcd_7seg
  import afisaj_7seg_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/afisaj_7seg_mux.sv
// Four-digit common-anode display scanner with per-frame digit snapshot,
// leading-zero blanking and a minutes separator that blinks while paused.
module afisaj_7seg_mux
  import afisaj_7seg_mux_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125,
  parameter bit BLANK_LEAD   = 1'b1
) (
  input  logic       clk,
  input  logic       reseteaza,
  input  logic       pauza,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  digit_idx_t         idx_q, idx_d;
  logic [15:0]        snap_q, snap_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               blink_q, blink_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               tick;
  logic               frame_end;
  logic [3:0]         cur_digit;
  logic [6:0]         dec_seg;

  decod_bcd_7seg u_decod (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    tick      = (scan_cnt_q == SCAN_LAST);
    frame_end = tick && (idx_q == 2'd3);

    scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;

    // All four digits are taken together at the frame boundary so a frame never mixes old and new time.
    if (frame_end) begin
      snap_d = {BCD3, BCD2, BCD1, BCD0};
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = snap_q[3:0];
    case (idx_q)
      2'd0:    cur_digit = snap_q[3:0];
      2'd1:    cur_digit = snap_q[7:4];
      2'd2:    cur_digit = snap_q[11:8];
      default: cur_digit = snap_q[15:12];
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = dec_seg;
    if (BLANK_LEAD && (idx_q == 2'd3) && (cur_digit == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
    dp_d = ~((idx_q == 2'd2) && (!pauza || blink_q));
  end

  always_ff @(posedge clk or negedge reseteaza) begin
    if (!reseteaza) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      snap_q      <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
